// File: rtl/calc_pkg.sv
// Shared calculator types: the BCD operand passed between keypad entry and the ALU.
package calc_pkg;
    localparam int NumDigits = 8;
    localparam int ExpW      = 3;

    typedef struct packed {
        logic                        error;
        logic                        sign;
        logic [ExpW-1:0]             exponent;
        logic [NumDigits-1:0][3:0]   sig;
    } num_t;
endpackage

// File: rtl/num_entry_if.sv
// Key-event and operand handshakes between keypad, num_entry and the ALU.
interface num_entry_if;
    logic               key_valid_i;
    logic [3:0]         key_code_i;
    logic               key_ready_o;
    calc_pkg::num_t     disp_num_o;
    calc_pkg::num_t     num_o;
    logic               num_valid_o;
    logic               num_ready_i;

    modport master (
        output key_valid_i, key_code_i, num_ready_i,
        input  key_ready_o, disp_num_o, num_o, num_valid_o
    );
    modport slave (
        input  key_valid_i, key_code_i, num_ready_i,
        output key_ready_o, disp_num_o, num_o, num_valid_o
    );
endinterface

// File: rtl/num_entry.sv
// Keypad operand entry: accumulates BCD digits, sign and exponent, then hands the
// finished operand to the ALU.
//   state   | meaning
//   EMPTY   | operand is zero, no digits entered
//   ENTRY   | at least one nonzero digit present
//   ERROR   | overflow, operand holds only the error flag
//   HOLD    | operand offered to the ALU, keys stalled
module num_entry #(
    parameter int NumDigits = calc_pkg::NumDigits,
    parameter int MaxExp    = 7
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    num_entry_if.slave   bus
);
    typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_ERROR, S_HOLD} state_e;

    localparam logic [3:0]      KeyNeg  = 4'hA;
    localparam logic [3:0]      KeyClr  = 4'hB;
    localparam logic [3:0]      KeyBs   = 4'hC;
    localparam logic [3:0]      KeyEnt  = 4'hD;
    localparam int              CntW    = $clog2(NumDigits + 1);
    localparam int              ExpW    = calc_pkg::ExpW;
    localparam logic [CntW-1:0] CntFull = CntW'(NumDigits);
    localparam logic [ExpW-1:0] ExpMax  = ExpW'(MaxExp);

    state_e           state_q, state_d;
    calc_pkg::num_t   opnd_q, opnd_d;
    calc_pkg::num_t   out_q, out_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EMPTY;
            opnd_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        if (state_q == S_HOLD) begin
            if (bus.num_ready_i) begin
                state_d = S_EMPTY;
                opnd_d  = '0;
                cnt_d   = '0;
            end
        end else if (bus.key_valid_i) begin
            case (bus.key_code_i)
                KeyNeg: if (state_q == S_ENTRY) opnd_d.sign = ~opnd_q.sign;
                KeyClr: begin
                    state_d = S_EMPTY;
                    opnd_d  = '0;
                    cnt_d   = '0;
                end
                KeyBs: if (state_q == S_ENTRY) begin
                    // Truncated digits are undone before real ones are removed.
                    if (opnd_q.exponent != '0) begin
                        opnd_d.exponent = opnd_q.exponent - ExpW'(1);
                    end else begin
                        opnd_d.sig = {4'h0, opnd_q.sig[NumDigits-1:1]};
                        cnt_d      = cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) begin
                            opnd_d.sign = 1'b0;
                            state_d     = S_EMPTY;
                        end
                    end
                end
                KeyEnt: begin
                    out_d   = opnd_q;
                    state_d = S_HOLD;
                end
                default: if (bus.key_code_i <= 4'd9) begin
                    if (state_q == S_EMPTY) begin
                        if (bus.key_code_i != 4'd0) begin
                            opnd_d.sig[0] = bus.key_code_i;
                            cnt_d         = CntW'(1);
                            state_d       = S_ENTRY;
                        end
                    end else if (state_q == S_ENTRY) begin
                        if (cnt_q != CntFull) begin
                            opnd_d.sig = {opnd_q.sig[NumDigits-2:0], bus.key_code_i};
                            cnt_d      = cnt_q + CntW'(1);
                        end else if (opnd_q.exponent != ExpMax) begin
                            opnd_d.exponent = opnd_q.exponent + ExpW'(1);
                        end else begin
                            opnd_d       = '0;
                            opnd_d.error = 1'b1;
                            cnt_d        = '0;
                            state_d      = S_ERROR;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.key_ready_o = (state_q != S_HOLD);
    assign bus.num_valid_o = (state_q == S_HOLD);
    assign bus.disp_num_o  = opnd_q;
    assign bus.num_o       = out_q;
endmodule

// File: tb/tb_num_entry.sv
// Directed bench for num_entry with a digit-list reference model checked every cycle.
module tb_num_entry;
    typedef calc_pkg::num_t num_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    num_entry_if bus();

    num_entry u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic num_t lit(input bit e, input bit s, input int x, input logic [31:0] sig);
        num_t r;
        r.error    = e;
        r.sign     = s;
        r.exponent = 3'(x);
        r.sig      = sig;
        return r;
    endfunction

    // Reference model: decimal digit list (MSD first), sign, exponent, error.
    int   m_digs[$];
    int   m_ex;
    bit   m_sgn, m_err, m_hold;
    num_t m_held;
    int   m_xfers = 0;

    function automatic num_t mk(input int q[$], input int ex, input bit s, input bit e);
        num_t   r = '0;
        longint v = 0;
        if (e) begin
            r.error = 1'b1;
        end else begin
            foreach (q[i]) v = v * 10 + q[i];
            for (int k = 0; k < 8; k++) begin
                r.sig[k] = 4'(v % 10);
                v = v / 10;
            end
            r.sign     = s;
            r.exponent = 3'(ex);
        end
        return r;
    endfunction

    task automatic m_clear();
        m_digs.delete();
        m_ex  = 0;
        m_sgn = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic m_key(input int c);
        if (c <= 9) begin
            if (!m_err) begin
                if (m_digs.size() == 0) begin
                    if (c != 0) m_digs.push_back(c);
                end else if (m_digs.size() < 8) m_digs.push_back(c);
                else if (m_ex < 7) m_ex++;
                else begin
                    m_clear();
                    m_err = 1'b1;
                end
            end
        end else if (c == 10) begin
            if (!m_err && m_digs.size() > 0) m_sgn = !m_sgn;
        end else if (c == 11) begin
            m_clear();
        end else if (c == 12) begin
            if (!m_err && m_digs.size() > 0) begin
                if (m_ex > 0) m_ex--;
                else void'(m_digs.pop_back());
                if (m_digs.size() == 0) m_sgn = 1'b0;
            end
        end else if (c == 13) begin
            m_held = mk(m_digs, m_ex, m_sgn, m_err);
            m_hold = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (bus.num_ready_i) begin
                m_xfers++;
                m_hold = 1'b0;
                m_clear();
            end
        end else if (bus.key_valid_i) begin
            m_key(int'(bus.key_code_i));
        end
    end

    // Per-cycle compare and transfer monitor; inputs change only #1 after posedge.
    int   dut_xfers = 0;
    int   vcyc = 0;
    num_t dut_last = '0;

    always @(negedge clk) begin
        check("key_ready", 64'(bus.key_ready_o), 64'(!m_hold));
        check("num_valid", 64'(bus.num_valid_o), 64'(m_hold));
        check("disp_num", 64'(bus.disp_num_o), 64'(mk(m_digs, m_ex, m_sgn, m_err)));
        if (m_hold) check("num_o", 64'(bus.num_o), 64'(m_held));
        if (bus.num_valid_o) vcyc++;
        if (rst_n && bus.num_valid_o && bus.num_ready_i) begin
            dut_xfers++;
            dut_last = bus.num_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int c);
        int n = 0;
        while (!bus.key_ready_o && n < 20) begin
            tick(1);
            n++;
        end
        check("press_ready", 64'(bus.key_ready_o), 64'(1));
        bus.key_valid_i = 1'b1;
        bus.key_code_i  = 4'(c);
        tick(1);
        bus.key_valid_i = 1'b0;
    endtask

    initial begin
        int v0;
        int x0;
        bus.key_valid_i = 1'b0;
        bus.key_code_i  = 4'h0;
        bus.num_ready_i = 1'b0;
        #2;
        check("rst_ready", 64'(bus.key_ready_o), 64'(1));
        check("rst_valid", 64'(bus.num_valid_o), 64'(0));
        check("rst_disp", 64'(bus.disp_num_o), 64'(0));
        check("rst_num", 64'(bus.num_o), 64'(0));
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // 1,2,3,ENTER with ALU ready
        bus.num_ready_i = 1'b1;
        press(1); press(2); press(3);
        check("t1_disp", 64'(bus.disp_num_o), 64'(lit(0, 0, 0, 32'h00000123)));
        v0 = vcyc;
        press(13);
        tick(3);
        check("t1_xfer", 64'(dut_last), 64'(lit(0, 0, 0, 32'h00000123)));
        check("t1_vcyc", 64'(vcyc - v0), 64'(1));
        check("t1_empty", 64'(bus.disp_num_o), 64'(0));

        // leading zeros, negate; negate in EMPTY
        press(0); press(0); press(5); press(10); press(13);
        tick(2);
        check("t2_neg5", 64'(dut_last), 64'(lit(0, 1, 0, 32'h00000005)));
        press(10); press(13);
        tick(2);
        check("t2_zero", 64'(dut_last), 64'(lit(0, 0, 0, 32'h0)));

        // truncation and backspace
        for (int d = 1; d <= 8; d++) press(d);
        press(9); press(9);
        check("t3_exp2", 64'(bus.disp_num_o), 64'(lit(0, 0, 2, 32'h12345678)));
        press(12);
        check("t3_exp1", 64'(bus.disp_num_o), 64'(lit(0, 0, 1, 32'h12345678)));
        press(12); press(12); press(12);
        check("t3_bs", 64'(bus.disp_num_o), 64'(lit(0, 0, 0, 32'h00123456)));
        press(11);

        // exponent overflow into ERROR
        for (int d = 1; d <= 8; d++) press(d);
        for (int i = 0; i < 7; i++) press(9);
        check("t4_exp7", 64'(bus.disp_num_o), 64'(lit(0, 0, 7, 32'h12345678)));
        press(9);
        check("t4_err", 64'(bus.disp_num_o), 64'(lit(1, 0, 0, 32'h0)));
        press(3); press(10); press(12); press(14); press(15);
        check("t4_err_hold", 64'(bus.disp_num_o), 64'(lit(1, 0, 0, 32'h0)));
        press(13);
        tick(2);
        check("t4_xfer", 64'(dut_last), 64'(lit(1, 0, 0, 32'h0)));
        for (int i = 0; i < 16; i++) press(i % 9 + 1);
        check("t4_err2", 64'(bus.disp_num_o), 64'(lit(1, 0, 0, 32'h0)));
        press(11);
        check("t4_clear", 64'(bus.disp_num_o), 64'(0));
        press(5);
        check("t4_recover", 64'(bus.disp_num_o), 64'(lit(0, 0, 0, 32'h5)));
        press(11);

        // ALU stalls while keys keep arriving
        bus.num_ready_i = 1'b0;
        press(4); press(2); press(13);
        bus.key_valid_i = 1'b1;
        bus.key_code_i  = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t5_stall_ready", 64'(bus.key_ready_o), 64'(0));
            check("t5_stall_num", 64'(bus.num_o), 64'(lit(0, 0, 0, 32'h42)));
        end
        x0 = dut_xfers;
        bus.num_ready_i = 1'b1;
        tick(1);
        check("t5_ready_back", 64'(bus.key_ready_o), 64'(1));
        check("t5_xfer", 64'(dut_xfers - x0), 64'(1));
        tick(1);
        bus.key_valid_i = 1'b0;
        check("t5_next_key", 64'(bus.disp_num_o), 64'(lit(0, 0, 0, 32'h1)));
        press(11);

        // async reset while holding
        bus.num_ready_i = 1'b0;
        press(7); press(13);
        x0 = dut_xfers;
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 64'(bus.num_valid_o), 64'(0));
        check("t6_disp", 64'(bus.disp_num_o), 64'(0));
        check("t6_num", 64'(bus.num_o), 64'(0));
        check("t6_ready", 64'(bus.key_ready_o), 64'(1));
        bus.num_ready_i = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("t6_noxfer", 64'(dut_xfers - x0), 64'(0));
        check("xfer_total", 64'(dut_xfers), 64'(m_xfers));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
